// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions (receiver and transmitter side):
//            FSM state encoding, oversampling timing, FIFO depth.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;
  localparam int FIFO_DEPTH = 4;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 4-deep synchronous FIFO, pointer-based full/empty. A write into
//            a full FIFO is accepted only if a read happens in the same cycle;
//            otherwise it is dropped and flagged on drop_o.
// Revision : 1.0
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          drop_o
);

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [2:0]    wptr_q;
  logic [2:0]    rptr_q;
  logic          do_rd;
  logic          do_wr;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[1:0] == rptr_q[1:0]) && (wptr_q[2] != rptr_q[2]);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign drop_o    = wr_en_i && full_o && !do_rd;
  assign rd_data_o = mem_q[rptr_q[1:0]];

  // Pointer and storage update; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= 3'd0;
      rptr_q <= 3'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem_q[wptr_q[1:0]] <= wr_data_i;
        wptr_q             <= wptr_q + 3'd1;
      end
      if (do_rd) begin
        rptr_q <= rptr_q + 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 16x-oversampled UART receiver (start, WIDTH data LSB first,
//            parity, stop). Received words plus parity/frame error flags are
//            queued in a 4-entry FIFO; a sticky Overrun marks dropped frames.
// Revision : 1.0
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_tick,
  input  logic             Rx,
  input  logic             FIFO_read,
  input  logic             Clear_Err,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Parity_Err,
  output logic             Frame_Err,
  output logic             FIFO_empty,
  output logic             FIFO_full,
  output logic             Overrun,
  output logic             Rx_Busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  uart_state_e      state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic             prev_rx_q, prev_rx_d;
  logic [3:0]       tick_q, tick_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             perr_q, perr_d;
  logic             overrun_q;

  logic             fifo_wr;
  logic [WIDTH+1:0] fifo_wdata;
  logic [WIDTH+1:0] fifo_rdata;
  logic             fifo_drop;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      prev_rx_q <= 1'b1;
      tick_q    <= 4'd0;
      bit_q     <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_rx_q <= prev_rx_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
    end
  end

  // Next-state logic; every transition is gated by sample_tick.
  always_comb begin
    state_d    = state_q;
    prev_rx_d  = prev_rx_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    fifo_wr    = 1'b0;
    fifo_wdata = {1'b0, perr_q, shift_q};
    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          // Only a 1->0 transition starts a frame, so a held-low break is ignored.
          prev_rx_d = rx_s_q;
          if (prev_rx_q && !rx_s_q) begin
            state_d = START;
            tick_d  = 4'd0;
          end
        end
        START: begin
          if (tick_q == 4'(MID_TICK)) begin
            if (!rx_s_q) begin
              state_d = DATA;
              tick_d  = 4'd0;
              bit_d   = '0;
            end else begin
              state_d   = IDLE;
              prev_rx_d = rx_s_q;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        DATA: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'(OVERSAMPLE - 1)) begin
            shift_d = {rx_s_q, shift_q[WIDTH-1:1]};
            if (bit_q == BW'(WIDTH - 1)) begin
              state_d = PARITY;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
        PARITY: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'(OVERSAMPLE - 1)) begin
            perr_d  = ((^shift_q) ^ rx_s_q) != PARITY_ODD;
            state_d = STOP;
          end
        end
        STOP: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'(OVERSAMPLE - 1)) begin
            fifo_wr    = 1'b1;
            fifo_wdata = {~rx_s_q, perr_q, shift_q};
            state_d    = IDLE;
            prev_rx_d  = rx_s_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sticky overrun; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q <= 1'b0;
    end else if (fifo_drop) begin
      overrun_q <= 1'b1;
    end else if (Clear_Err) begin
      overrun_q <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DW (WIDTH + 2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (FIFO_read),
    .rd_data_o (fifo_rdata),
    .empty_o   (FIFO_empty),
    .full_o    (FIFO_full),
    .drop_o    (fifo_drop)
  );

  assign Data_Out   = fifo_rdata[WIDTH-1:0];
  assign Parity_Err = fifo_rdata[WIDTH];
  assign Frame_Err  = fifo_rdata[WIDTH+1];
  assign Overrun    = overrun_q;
  assign Rx_Busy    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx: frame-level reference model
//            (expected FIFO contents, overrun, busy windows) compared every
//            cycle, plus literal checks of the directed scenarios.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

  localparam int W = 8;
  // One frame: start + W data + parity + stop, 16 clocks each. The stop bit
  // is sampled (and written) 10 + 16*(W+2) edges after Rx first reads 0:
  // 2 synchronizer edges, 1 edge-detect edge, 7 ticks to mid start, then
  // 16 edges per following bit.
  localparam int COMMIT_OFS = 10 + 16 * (W + 2);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sample_tick = 1'b1;
  logic         Rx = 1'b1;
  logic         FIFO_read = 1'b0;
  logic         Clear_Err = 1'b0;
  logic [W-1:0] Data_Out, Data_Out_odd;
  logic         Parity_Err, Frame_Err, FIFO_empty, FIFO_full, Overrun, Rx_Busy;
  logic         Parity_Err_odd, Frame_Err_odd, FIFO_empty_odd, FIFO_full_odd;
  logic         Overrun_odd, Rx_Busy_odd;

  uart_rx #(.WIDTH(W), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .Rx(Rx),
    .FIFO_read(FIFO_read), .Clear_Err(Clear_Err),
    .Data_Out(Data_Out), .Parity_Err(Parity_Err), .Frame_Err(Frame_Err),
    .FIFO_empty(FIFO_empty), .FIFO_full(FIFO_full), .Overrun(Overrun),
    .Rx_Busy(Rx_Busy)
  );

  uart_rx #(.WIDTH(W), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .Rx(Rx),
    .FIFO_read(FIFO_read), .Clear_Err(Clear_Err),
    .Data_Out(Data_Out_odd), .Parity_Err(Parity_Err_odd), .Frame_Err(Frame_Err_odd),
    .FIFO_empty(FIFO_empty_odd), .FIFO_full(FIFO_full_odd), .Overrun(Overrun_odd),
    .Rx_Busy(Rx_Busy_odd)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  logic [W+1:0] exp_q[$];
  int           pend_cyc[$];
  logic [W+1:0] pend_ent[$];
  bit           exp_ov = 1'b0;
  int           bstart = -1;
  int           bend = -1;
  bit           chk_on = 1'b0;
  bit           rand_rd = 1'b0;
  int           rd_at = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: frame completions land in the expected FIFO at their commit edge.
  always @(posedge clk) begin
    bit           rd;
    bit           wr;
    logic [W+1:0] ent;
    cyc = cyc + 1;
    ent = '0;
    if (rst) begin
      rd = FIFO_read && (exp_q.size() > 0);
      wr = (pend_cyc.size() > 0) && (pend_cyc[0] == cyc);
      if (wr) begin
        ent = pend_ent[0];
        void'(pend_cyc.pop_front());
        void'(pend_ent.pop_front());
      end
      if (Clear_Err) exp_ov = 1'b0;
      if (wr && exp_q.size() == 4 && !rd) begin
        exp_ov = 1'b1;
      end else begin
        if (rd) void'(exp_q.pop_front());
        if (wr) exp_q.push_back(ent);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst && chk_on) begin
      check("empty", 32'(FIFO_empty), 32'(exp_q.size() == 0));
      check("full", 32'(FIFO_full), 32'(exp_q.size() == 4));
      check("overrun", 32'(Overrun), 32'(exp_ov));
      check("busy", 32'(Rx_Busy), 32'((cyc >= bstart) && (cyc < bend)));
      if (exp_q.size() > 0)
        check("head", 32'({Frame_Err, Parity_Err, Data_Out}), 32'(exp_q[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rd) begin
      FIFO_read = ($urandom_range(0, 3) == 0);
      Clear_Err = ($urandom_range(0, 15) == 0);
    end else begin
      FIFO_read = (rd_at == cyc + 1);
      Clear_Err = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) step();
  endtask

  task automatic pulse_read();
    FIFO_read = 1'b1;
    @(posedge clk);
    #1;
    FIFO_read = 1'b0;
  endtask

  // Drives one frame. pflip inverts the correct even parity bit; stop_v is the
  // stop bit; low_hold keeps the line low afterwards (break).
  task automatic send_frame(input logic [W-1:0] d, input bit pflip, input bit stop_v,
                            input int low_hold, input bit rd_commit);
    int   e0;
    logic pbit;
    pbit   = (^d) ^ pflip;
    e0     = cyc + 1;
    bstart = e0 + 2;
    bend   = e0 + COMMIT_OFS;
    if (rd_commit) rd_at = bend;
    pend_cyc.push_back(bend);
    pend_ent.push_back({~stop_v, ((^d) ^ pbit) != 1'b0, d});
    Rx = 1'b0;
    repeat (16) step();
    for (int i = 0; i < W; i++) begin
      Rx = d[i];
      repeat (16) step();
    end
    Rx = pbit;
    repeat (16) step();
    Rx = stop_v;
    repeat (16) step();
    if (low_hold > 0) begin
      Rx = 1'b0;
      repeat (low_hold) step();
    end
    Rx = 1'b1;
    rd_at = -1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend_cyc.delete();
    pend_ent.delete();
    exp_ov = 1'b0;
    bstart = -1;
    bend   = -1;
  endtask

  initial begin
    int e0;
    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", 32'(FIFO_empty), 32'd1);
    check("rst_full", 32'(FIFO_full), 32'd0);
    check("rst_overrun", 32'(Overrun), 32'd0);
    check("rst_busy", 32'(Rx_Busy), 32'd0);
    check("rst_data", 32'({Frame_Err, Parity_Err, Data_Out}), 32'd0);
    rst = 1'b1;
    chk_on = 1'b1;
    idle(5);

    // Clean even-parity frame.
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
    check("a5_empty", 32'(FIFO_empty), 32'd0);
    check("a5_data", 32'(Data_Out), 32'hA5);
    check("a5_perr", 32'(Parity_Err), 32'd0);
    check("a5_ferr", 32'(Frame_Err), 32'd0);
    pulse_read();
    check("a5_read_empty", 32'(FIFO_empty), 32'd1);

    // Parity bit 1: bad for even, good for odd.
    idle(3);
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
    check("a5p_data", 32'(Data_Out), 32'hA5);
    check("a5p_perr", 32'(Parity_Err), 32'd1);
    check("a5p_ferr", 32'(Frame_Err), 32'd0);
    check("a5p_odd_data", 32'(Data_Out_odd), 32'hA5);
    check("a5p_odd_perr", 32'(Parity_Err_odd), 32'd0);
    pulse_read();

    // Frame error followed by a 40-clock break, then a clean frame.
    idle(3);
    send_frame(8'h3C, 1'b0, 1'b0, 40, 1'b0);
    check("brk_data", 32'(Data_Out), 32'h3C);
    check("brk_ferr", 32'(Frame_Err), 32'd1);
    idle(20);
    check("brk_busy", 32'(Rx_Busy), 32'd0);
    pulse_read();
    check("brk_one_entry", 32'(FIFO_empty), 32'd1);
    send_frame(8'h55, 1'b0, 1'b1, 0, 1'b0);
    check("after_brk", 32'({Frame_Err, Parity_Err, Data_Out}), 32'h055);
    pulse_read();

    // Start-bit glitch of 4 clocks.
    idle(5);
    e0 = cyc + 1;
    bstart = e0 + 2;
    bend = e0 + 10;
    Rx = 1'b0;
    repeat (4) step();
    idle(20);
    check("glitch_busy", 32'(Rx_Busy), 32'd0);
    check("glitch_empty", 32'(FIFO_empty), 32'd1);

    // Fill, overflow, drain, clear.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b0, 1'b1, 0, 1'b0);
      if (i == 4) check("full_after4", 32'(FIFO_full), 32'd1);
    end
    check("overrun_after5", 32'(Overrun), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("drain", 32'(Data_Out), 32'(i));
      pulse_read();
    end
    check("drained_empty", 32'(FIFO_empty), 32'd1);
    Clear_Err = 1'b1;
    @(posedge clk);
    #1;
    Clear_Err = 1'b0;
    check("clear_overrun", 32'(Overrun), 32'd0);

    // Write into a full FIFO with a read on the same edge.
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'h14, 1'b0, 1'b1, 0, 1'b1);
    check("wr_rd_full_ov", 32'(Overrun), 32'd0);
    check("wr_rd_full_head", 32'(Data_Out), 32'h11);
    check("wr_rd_full_full", 32'(FIFO_full), 32'd1);
    for (int i = 0; i < 4; i++) pulse_read();

    // Randomized frames, gaps, reads and clears.
    rand_rd = 1'b1;
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] d;
      bit           st;
      d  = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
      send_frame(d, ($urandom_range(0, 3) == 0), st,
                 st ? 0 : int'($urandom_range(0, 30)), 1'b0);
      idle(int'($urandom_range(4, 20)));
    end
    rand_rd = 1'b0;
    FIFO_read = 1'b0;
    Clear_Err = 1'b0;
    idle(4);

    // Reset in the middle of data bit 3.
    send_frame(8'h99, 1'b0, 1'b1, 0, 1'b0);
    e0 = cyc + 1;
    bstart = e0 + 2;
    bend = e0 + 100000;
    Rx = 1'b0;
    repeat (16) step();
    for (int i = 0; i < 3; i++) begin
      Rx = 1'b0;
      repeat (16) step();
    end
    Rx = 1'b1;
    repeat (8) step();
    rst = 1'b0;
    model_reset();
    #1;
    check("mid_rst_empty", 32'(FIFO_empty), 32'd1);
    check("mid_rst_full", 32'(FIFO_full), 32'd0);
    check("mid_rst_ov", 32'(Overrun), 32'd0);
    check("mid_rst_busy", 32'(Rx_Busy), 32'd0);
    check("mid_rst_data", 32'({Frame_Err, Parity_Err, Data_Out}), 32'd0);
    Rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(4);
    send_frame(8'h7E, 1'b0, 1'b1, 0, 1'b0);
    check("post_rst", 32'({Frame_Err, Parity_Err, Data_Out}), 32'h07E);
    pulse_read();
    idle(4);
    check("post_rst_empty", 32'(FIFO_empty), 32'd1);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
